// File: rtl/axil_reg_slave_if.sv
// AXI-Lite bus bundle shared by the register-bank slave and its host-side master.
// Address and data share DATA_WIDTH. There is one strobe bit per data byte.
interface axi_lite #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [DATA_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI-Lite register bank: REG_NUM byte-strobed control registers.
// Independent write (AW/W/B) and read (AR/R) state machines access the bank.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_lite.slave                        s_axil,
    output logic [REG_NUM*DATA_WIDTH-1:0] reg_q,
    output logic [REG_NUM-1:0]            wr_pulse
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(REG_NUM * BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_COLLECT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    logic                  aw_held;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [BYTES-1:0]      w_strb_q;
    logic                  aw_rdy;
    logic                  w_rdy;
    logic                  b_vld;
    logic [1:0]            b_resp;
    logic                  ar_rdy;
    logic                  r_vld;
    logic [1:0]            r_resp;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  w_ok;
    logic                  ar_ok;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      ar_idx;
    logic                  unused_prot;

    assign aw_hs  = s_axil.awvalid && aw_rdy;
    assign w_hs   = s_axil.wvalid && w_rdy;
    assign ar_hs  = s_axil.arvalid && ar_rdy;
    assign w_ok   = aw_addr_q < ADDR_LIMIT;
    assign ar_ok  = s_axil.araddr < ADDR_LIMIT;
    assign w_idx  = aw_addr_q[LSB +: IDX_W];
    assign ar_idx = s_axil.araddr[LSB +: IDX_W];
    assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

    assign s_axil.awready = aw_rdy;
    assign s_axil.wready  = w_rdy;
    assign s_axil.bvalid  = b_vld;
    assign s_axil.bresp   = b_resp;
    assign s_axil.arready = ar_rdy;
    assign s_axil.rvalid  = r_vld;
    assign s_axil.rresp   = r_resp;
    assign s_axil.rdata   = r_data;

    for (genvar i = 0; i < REG_NUM; i++) begin : g_reg_q
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    // AW and W are latched separately. The write fires one edge after both are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_COLLECT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_rdy    <= 1'b0;
            w_rdy     <= 1'b0;
            b_vld     <= 1'b0;
            b_resp    <= RESP_OKAY;
            wr_pulse  <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_COLLECT: begin
                    if (aw_held && w_held) begin
                        if (w_ok) begin
                            for (int b = 0; b < BYTES; b++) begin
                                if (w_strb_q[b]) begin
                                    regs[w_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
                                end
                            end
                            wr_pulse[w_idx] <= 1'b1;
                            b_resp          <= RESP_OKAY;
                        end else begin
                            b_resp <= RESP_SLVERR;
                        end
                        b_vld   <= 1'b1;
                        aw_rdy  <= 1'b0;
                        w_rdy   <= 1'b0;
                        w_state <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= s_axil.awaddr;
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= s_axil.wdata;
                            w_strb_q <= s_axil.wstrb;
                        end
                        aw_rdy <= !(aw_held || aw_hs);
                        w_rdy  <= !(w_held || w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        b_vld   <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        aw_rdy  <= 1'b1;
                        w_rdy   <= 1'b1;
                        w_state <= W_COLLECT;
                    end
                end
                default: w_state <= W_COLLECT;
            endcase
        end
    end

    // The read samples the bank with non-blocking semantics.
    // A read that coincides with a write therefore returns the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            ar_rdy  <= 1'b0;
            r_vld   <= 1'b0;
            r_resp  <= RESP_OKAY;
            r_data  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_data  <= ar_ok ? regs[ar_idx] : '0;
                        r_resp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                        r_vld   <= 1'b1;
                        ar_rdy  <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        ar_rdy <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axil.rready) begin
                        r_vld   <= 1'b0;
                        ar_rdy  <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave with REG_NUM=16 and 32-bit data.
// Expected values are written out by hand.
module tb_axil_reg_slave;
    logic         clk;
    logic         rst;
    logic [511:0] reg_q;
    logic [15:0]  wr_pulse;
    logic [511:0] exp_regs;
    logic [31:0]  exp_q[$];
    logic [1:0]   resp;
    logic [15:0]  pulse;
    int           n_checks = 0;
    int           n_pass = 0;

    axi_lite #(.DATA_WIDTH(32)) bus ();

    axil_reg_slave #(.DATA_WIDTH(32), .REG_NUM(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axil   (bus),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] bresp_o, output logic [15:0] pulse_o);
        int   t;
        logic aw_hs;
        logic w_hs;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        t = 0;
        while ((bus.awvalid || bus.wvalid) && t < 20) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs)  bus.wvalid  = 1'b0;
            t++;
        end
        if (t >= 20) begin
            check("write_hs_timeout", 1, 0);
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
        bus.bready = 1'b1;
        t = 0;
        while (!bus.bvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("bvalid_timeout", 1, 0);
        bresp_o = bus.bresp;
        pulse_o = wr_pulse;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read_check(input string tag, input logic [31:0] addr, input logic [1:0] exp_resp);
        int          t;
        logic [31:0] exp_data;
        exp_data    = exp_q.pop_front();
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check({tag, "_ar_timeout"}, 1, 0);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check({tag, "_rvalid"}, bus.rvalid, 1);
        check({tag, "_rdata"}, bus.rdata, exp_data);
        check({tag, "_rresp"}, bus.rresp, exp_resp);
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check({tag, "_rvalid_clr"}, bus.rvalid, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_reg_q", reg_q, 0);
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_arready", bus.arready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_awready", bus.awready, 1);
        check("rel_wready", bus.wready, 1);
        check("rel_arready", bus.arready, 1);

        // AW is held and W has not arrived when reset hits mid-write.
        bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        check("aw_held_awready", bus.awready, 0);
        check("aw_held_wready", bus.wready, 1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_awready", bus.awready, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_awready", bus.awready, 1);
        check("post_wready", bus.wready, 1);
        check("post_bvalid", bus.bvalid, 0);
        check("post_rvalid", bus.rvalid, 0);
        check("post_reg_q", reg_q, 0);
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("w_only_wready", bus.wready, 0);
        repeat (3) @(negedge clk);
        check("aw_discarded_bvalid", bus.bvalid, 0);
        check("aw_discarded_reg_q", reg_q, 0);
        bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        @(negedge clk);
        check("late_aw_bvalid", bus.bvalid, 1);
        check("late_aw_reg3", reg_q[3*32 +: 32], 32'h12345678);
        check("late_aw_pulse", wr_pulse, 16'h0008);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("late_aw_bvalid_clr", bus.bvalid, 0);
        check("late_aw_awready", bus.awready, 1);
        check("late_aw_wready", bus.wready, 1);

        // Simultaneous AW and W with a full strobe.
        bus.awaddr = 32'h08; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("sim_k_bvalid", bus.bvalid, 0);
        check("sim_k_pulse", wr_pulse, 0);
        @(negedge clk);
        check("sim_reg2", reg_q[95:64], 32'hDEADBEEF);
        check("sim_pulse", wr_pulse, 16'h0004);
        check("sim_bvalid", bus.bvalid, 1);
        check("sim_bresp", bus.bresp, 2'b00);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("sim_pulse_width", wr_pulse, 0);
        check("sim_bvalid_clr", bus.bvalid, 0);
        exp_q.push_back(32'hDEADBEEF);
        axi_read_check("rd_0x08", 32'h08, 2'b00);

        // W arrives first with a partial strobe. AW follows three cycles later.
        axi_write(32'h04, 32'h11223344, 4'hF, resp, pulse);
        check("r1_init_bresp", resp, 2'b00);
        check("r1_init_pulse", pulse, 16'h0002);
        bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("wfirst_wready", bus.wready, 0);
        check("wfirst_awready", bus.awready, 1);
        repeat (2) @(negedge clk);
        bus.awaddr = 32'h04; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        check("wfirst_k_bvalid", bus.bvalid, 0);
        check("wfirst_k_reg1", reg_q[63:32], 32'h11223344);
        @(negedge clk);
        check("wfirst_bvalid", bus.bvalid, 1);
        check("wfirst_reg1", reg_q[63:32], 32'h11BB33DD);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;

        // Out-of-range address 0x40.
        exp_regs = '0;
        exp_regs[1*32 +: 32] = 32'h11BB33DD;
        exp_regs[2*32 +: 32] = 32'hDEADBEEF;
        exp_regs[3*32 +: 32] = 32'h12345678;
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, resp, pulse);
        check("oor_bresp", resp, 2'b10);
        check("oor_pulse", pulse, 0);
        check("oor_reg_q", reg_q, exp_regs);
        exp_q.push_back(32'h0);
        axi_read_check("rd_oor", 32'h40, 2'b10);

        // Backpressure on B for 5 cycles and on R for 4 cycles.
        bus.awaddr = 32'h14; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", bus.bvalid, 1);
            check("bp_bresp", bus.bresp, 2'b00);
            check("bp_awready", bus.awready, 0);
            check("bp_wready", bus.wready, 0);
            @(negedge clk);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bp_bvalid_clr", bus.bvalid, 0);
        check("bp_awready_up", bus.awready, 1);
        check("bp_wready_up", bus.wready, 1);
        check("bp_reg5", reg_q[5*32 +: 32], 32'hCAFEF00D);
        bus.araddr = 32'h14; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_rvalid", bus.rvalid, 1);
            check("bp_rdata", bus.rdata, 32'hCAFEF00D);
            check("bp_rresp", bus.rresp, 2'b00);
            check("bp_arready", bus.arready, 0);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("bp_rvalid_clr", bus.rvalid, 0);
        check("bp_arready_up", bus.arready, 1);

        // The AR handshake lands on the same edge that writes register 2.
        axi_write(32'h08, 32'h5, 4'hF, resp, pulse);
        check("col_init_bresp", resp, 2'b00);
        bus.awaddr = 32'h08; bus.wdata = 32'h9; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h08; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("col_rvalid", bus.rvalid, 1);
        check("col_rdata_old", bus.rdata, 32'h5);
        check("col_reg2_new", reg_q[95:64], 32'h9);
        check("col_bvalid", bus.bvalid, 1);
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        exp_q.push_back(32'h9);
        axi_read_check("rd_after_col", 32'h08, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
